// File: rtl/rv_pkg.sv
// Shared constants for the register write-back path.
// Contents:
//   RV_XLEN       - default data width
//   RV_REG_AW     - register-address width
//   RV_NUM_REGS   - number of architectural registers
//   RV_FIFO_DEPTH - default depth of the load-result queue
//   reg_onehot()  - decodes a register address into a one-hot bit vector
package rv_pkg;

  localparam int RV_XLEN       = 32;
  localparam int RV_REG_AW     = 5;
  localparam int RV_NUM_REGS   = 32;
  localparam int RV_FIFO_DEPTH = 2;

  function automatic logic [RV_NUM_REGS-1:0] reg_onehot(input logic [RV_REG_AW-1:0] rd);
    logic [RV_NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue: a small synchronous FIFO.
// Ports:
//   clock, reset     - rising-edge clock, asynchronous active-low reset
//   i_push, i_din    - write one entry (ignored while full)
//   i_pop            - drop the head entry (ignored while empty)
//   o_dout           - current head entry (valid while !o_empty)
//   o_full, o_empty  - occupancy flags, derived from the registered pointers
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between a push and its pop.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Register-file write-port arbiter with a load-result queue and busy scoreboard.
// Ports:
//   clock, reset                  - rising-edge clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     - single-cycle ALU result, no back-pressure
//   mem_valid/mem_ready/mem_rd/mem_data - load result offered to the queue
//   issue_valid/issue_rd          - long-latency instruction issue, marks rd busy
//   rs1/rs2, busy_rs1/busy_rs2    - decode source lookup against the busy vector
//   write_reg/write_data/regwrite - registered register-file write port
//   conflict_cnt                  - saturating count of cycles the ALU pre-empts a waiting load
//
// Handshake: a load result transfers on a rising edge where mem_valid and
// mem_ready are both high. mem_ready depends only on registered FIFO occupancy
// (never on mem_valid or the same-cycle pop), so it is stable for the whole
// cycle, and mem_data/mem_rd must be held while mem_valid waits for ready.
module reg_write_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN       = RV_XLEN,
  parameter int FIFO_DEPTH = RV_FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [RV_REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [RV_REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 issue_valid,
  input  logic [RV_REG_AW-1:0] issue_rd,
  input  logic [RV_REG_AW-1:0] rs1,
  input  logic [RV_REG_AW-1:0] rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2,
  output logic [RV_REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]      write_data,
  output logic                 regwrite,
  output logic [15:0]          conflict_cnt
);

  localparam int          EW      = RV_REG_AW + XLEN;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic                   r_regwrite;
  logic [RV_REG_AW-1:0]   r_write_reg;
  logic [XLEN-1:0]        r_write_data;
  logic [15:0]            r_conflict_cnt;
  logic [RV_NUM_REGS-1:0] r_busy;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [EW-1:0]          w_head;
  logic [RV_REG_AW-1:0]   w_head_rd;
  logic [XLEN-1:0]        w_head_data;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_sel_valid;
  logic [RV_REG_AW-1:0]   w_sel_rd;
  logic [XLEN-1:0]        w_sel_data;
  logic [RV_NUM_REGS-1:0] w_busy_next;

  assign mem_ready = !w_fifo_full;
  assign w_push    = mem_valid && mem_ready;
  // The ALU has no back-pressure, so it always wins and the queue waits.
  assign w_pop     = !alu_valid && !w_fifo_empty;

  assign w_head_rd   = w_head[XLEN +: RV_REG_AW];
  assign w_head_data = w_head[XLEN-1:0];

  wb_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({mem_rd, mem_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_data;
    end else if (!w_fifo_empty) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = w_head_rd;
      w_sel_data  = w_head_data;
    end
  end

  // Clear for the popped load first, then the issue set, so a same-cycle
  // set on the same register survives.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop) w_busy_next = w_busy_next & ~reg_onehot(w_head_rd);
    if (issue_valid && (issue_rd != '0)) w_busy_next = w_busy_next | reg_onehot(issue_rd);
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_regwrite     <= 1'b0;
      r_write_reg    <= '0;
      r_write_data   <= '0;
      r_conflict_cnt <= '0;
      r_busy         <= '0;
    end else begin
      // rd=0 results are consumed by the selection above but never written.
      r_regwrite <= w_sel_valid && (w_sel_rd != '0);
      if (w_sel_valid && (w_sel_rd != '0)) begin
        r_write_reg  <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
      if (alu_valid && !w_fifo_empty && (r_conflict_cnt != CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
      r_busy <= w_busy_next;
    end
  end

  assign regwrite     = r_regwrite;
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign conflict_cnt = r_conflict_cnt;
  assign busy_rs1     = r_busy[rs1];
  assign busy_rs2     = r_busy[rs2];

endmodule

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width; FIFO_DEPTH, default 2, depth of the load-result queue (power of two, at least 2).
REQ-002 Ports SHALL be as listed; clock and reset come first.
- clock  input  1  sole clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  single-cycle ALU result present; no back-pressure.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load/multi-cycle result offered.
- mem_ready  output  1  load result accepted when mem_valid and mem_ready are both high.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load result.
- issue_valid  input  1  a long-latency instruction is issued.
- issue_rd  input  5  destination of the issued instruction.
- rs1, rs2  input  5 each  decode source registers to check.
- busy_rs1, busy_rs2  output  1 each  the source has a pending long-latency write.
- write_reg  output  5  register-file write address.
- write_data  output  XLEN  register-file write data.
- regwrite  output  1  register-file write enable.
- conflict_cnt  output  16  saturating count of cycles where the ALU pre-empts a waiting load.

Function
REQ-003 Write-port outputs SHALL be registered; an ALU result sampled in cycle N SHALL appear on write_reg/write_data/regwrite in cycle N+1.
REQ-004 Accepted load results SHALL enter a FIFO of FIFO_DEPTH entries; the earliest pop is the cycle after the push, so the minimum load write latency is 2 cycles.
REQ-005 mem_ready SHALL be high exactly when the FIFO occupancy, as registered at the start of the cycle, is below FIFO_DEPTH; a push into a full FIFO SHALL never occur.
REQ-006 Arbitration, per cycle:
- alu_valid=1: the ALU result is selected and the FIFO is not popped.
- alu_valid=0 and FIFO non-empty: the FIFO head is selected and popped.
- otherwise: nothing is selected and regwrite is 0 next cycle.
REQ-007 A push and a pop in the same cycle SHALL leave the occupancy unchanged and preserve FIFO order; wrap-around of the read and write pointers SHALL be transparent.
REQ-008 A selected result with rd=0 SHALL be consumed (popped or dropped) but SHALL drive regwrite=0; x0 is never written.
REQ-009 The scoreboard SHALL be a 32-bit busy vector:
- issue_valid with issue_rd≠0 sets the bit for issue_rd.
- A load write-back of rd clears the bit for rd.
- If a set and a clear hit the same rd in one cycle, the set wins.
- Bit 0 is always 0.
REQ-010 busy_rs1 and busy_rs2 SHALL be combinational lookups of the registered busy vector. A clear takes effect the cycle after the pop, which is the same cycle regwrite is asserted for that write.
REQ-011 conflict_cnt SHALL increment in each cycle where alu_valid=1 and the FIFO is non-empty, and SHALL saturate at 16'hFFFF.
REQ-012 The ALU path SHALL NOT affect the busy vector.

Reset
REQ-013 While reset=0, asynchronously:
- regwrite, write_reg, write_data, conflict_cnt and the busy vector are 0.
- The FIFO is empty, so mem_ready=1 after release.
REQ-014 A reset asserted mid-operation SHALL discard all queued load results and pending busy bits; there is no partial write-back after release.

Structure
REQ-015 XLEN, the register-address width (5) and the default FIFO depth SHALL be constants in the shared package rv_pkg.
REQ-016 The load queue SHALL be a sub-module named wb_fifo, with push/pop/full/empty, instanced once. Arbitration, scoreboard and counter SHALL stay in reg_write_ctrl.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- ALU only: alu_valid=1, rd=5, data=32'hDEADBEEF in cycle 0 -> cycle 1 regwrite=1, write_reg=5, write_data=32'hDEADBEEF.
- Load and scoreboard: issue_rd=7 in cycle 0, then rs1=7 -> busy_rs1=1. Push load rd=7, data=32'h1234 in cycle 3 with no ALU -> write in cycle 5, and busy_rs1=0 from cycle 5.
- Contention: FIFO holds 2 loads and alu_valid=1 for 3 cycles -> mem_ready=0, ALU writes in cycles 1-3, loads write in cycles 4 and 5 in push order, conflict_cnt=3.
- x0: ALU rd=0 and a load rd=0 -> regwrite stays 0, the FIFO drains, the busy vector is unchanged.
- Same-cycle set and clear: issue_rd=9 in the same cycle the load rd=9 pops -> busy bit 9 remains 1.
- Reset mid-stream: FIFO holds 1 entry and busy bit 3=1, reset pulsed low -> regwrite=0, mem_ready=1, all busy bits 0, no stale write after release.
